// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file (regfile_sb).
// Optional build macro used across this slice: REGFILE_ZERO_REG_EN (r0 hardwired to zero).
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int NREGS      = 2 ** DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/issue, execute/writeback and the register file.
// The master side drives the request fields. The slave side is the register file.
interface regfile_sb_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
);

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_dst;
    logic              iss_ack;
    logic [CNT_W-1:0]  pend_cnt;
    logic              wb_err;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_dst,
        input  rd_data_a, rd_data_b, busy_a, busy_b, iss_ack, pend_cnt, wb_err
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_dst,
        output rd_data_a, rd_data_b, busy_a, busy_b, iss_ack, pend_cnt, wb_err
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy tracking: issue reserves a destination and writeback releases it.
// With REGFILE_ZERO_REG_EN defined, r0 can never be reserved and writes to it are ignored.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_iss_en,
    input  logic [ADDR_W-1:0] i_iss_dst,
    output logic              o_busy_a,
    output logic              o_busy_b,
    output logic              o_iss_ack,
    output logic [CNT_W-1:0]  o_pend_cnt,
    output logic              o_wb_err
);

    localparam int NUM_REGS = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_pend_cnt;
    logic                r_wb_err;

    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_iss_ack;
    logic                w_dst_zero;
    logic                w_wr_zero;
    logic                w_inc;
    logic                w_dec;
    logic                w_err_hit;

    // A writeback in the same cycle frees its register for a new reservation.
    // When both happen on one register, the set wins, so the new owner keeps it busy.
    always_comb begin
        w_set      = '0;
        w_clr      = '0;
        w_dst_zero = ZERO_EN && (i_iss_dst == '0);
        w_wr_zero  = ZERO_EN && (i_wr_addr == '0);
        w_iss_ack  = i_iss_en && (w_dst_zero || !r_busy[i_iss_dst] ||
                                  (i_wr_en && (i_wr_addr == i_iss_dst)));
        if (w_iss_ack && !w_dst_zero) begin
            w_set[i_iss_dst] = 1'b1;
        end
        if (i_wr_en && !w_wr_zero) begin
            w_clr[i_wr_addr] = 1'b1;
        end
        w_busy_nxt = w_set | (r_busy & ~w_clr);
        w_inc      = |(w_set & ~r_busy);
        w_dec      = |(w_clr & ~w_set & r_busy);
        w_err_hit  = i_wr_en && !w_wr_zero && !r_busy[i_wr_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= r_pend_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
            if (w_err_hit) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign o_busy_a   = r_busy[i_rd_addr_a] && !(i_wr_en && (i_wr_addr == i_rd_addr_a));
    assign o_busy_b   = r_busy[i_rd_addr_b] && !(i_wr_en && (i_wr_addr == i_rd_addr_b));
    assign o_iss_ack  = w_iss_ack;
    assign o_pend_cnt = r_pend_cnt;
    assign o_wb_err   = r_wb_err;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-to-read bypass and an issue scoreboard.
// Build option REGFILE_ZERO_REG_EN makes r0 read as zero and drop writes to it.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  rf_bus
);

    localparam int NUM_REGS = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data_a;
    logic [DATA_W-1:0] w_rd_data_b;

    assign w_wr_en = rf_bus.wr_en && !(ZERO_EN && (rf_bus.wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[rf_bus.wr_addr] <= rf_bus.wr_data;
        end
    end

    // Bypass lets a consumer see a writeback in the cycle it arrives. A hardwired r0 overrides even the bypass.
    always_comb begin
        w_rd_data_a = r_mem[rf_bus.rd_addr_a];
        if (rf_bus.wr_en && (rf_bus.wr_addr == rf_bus.rd_addr_a)) begin
            w_rd_data_a = rf_bus.wr_data;
        end
        if (ZERO_EN && (rf_bus.rd_addr_a == '0)) begin
            w_rd_data_a = '0;
        end

        w_rd_data_b = r_mem[rf_bus.rd_addr_b];
        if (rf_bus.wr_en && (rf_bus.wr_addr == rf_bus.rd_addr_b)) begin
            w_rd_data_b = rf_bus.wr_data;
        end
        if (ZERO_EN && (rf_bus.rd_addr_b == '0)) begin
            w_rd_data_b = '0;
        end
    end

    assign rf_bus.rd_data_a = w_rd_data_a;
    assign rf_bus.rd_data_b = w_rd_data_b;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_addr_a (rf_bus.rd_addr_a),
        .i_rd_addr_b (rf_bus.rd_addr_b),
        .i_wr_en     (rf_bus.wr_en),
        .i_wr_addr   (rf_bus.wr_addr),
        .i_iss_en    (rf_bus.iss_en),
        .i_iss_dst   (rf_bus.iss_dst),
        .o_busy_a    (rf_bus.busy_a),
        .o_busy_b    (rf_bus.busy_b),
        .o_iss_ack   (rf_bus.iss_ack),
        .o_pend_cnt  (rf_bus.pend_cnt),
        .o_wb_err    (rf_bus.wb_err)
    );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- Adds async active-low reset clearing, write-to-read bypass, and a per-register scoreboard: issue marks a destination busy, writeback clears it.
- Sits between decode/issue and execute/writeback; decode uses busy flags and iss_ack to stall on RAW/WAW hazards.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W.
- CNT_W, ADDR_W+1, width of pending-count output; must hold the value NREGS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  read port A data, combinational.
- rd_data_b  out  DATA_W  read port B data, combinational.
- busy_a  out  1  register at rd_addr_a is pending writeback.
- busy_b  out  1  register at rd_addr_b is pending writeback.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback index.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue request; reserves iss_dst.
- iss_dst  in  ADDR_W  destination register of the issuing instruction.
- iss_ack  out  1  combinational; issue accepted this cycle.
- pend_cnt  out  CNT_W  number of busy registers, registered.
- wb_err  out  1  sticky; writeback to a register that was not busy.

Behaviour:
- One clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, immediate, no clock needed):
  - All registers cleared to 0; all busy bits 0.
  - pend_cnt=0, wb_err=0.
  - Consequently rd_data_*=0, busy_*=0 and iss_ack=iss_en during reset release.
- Read, combinational, zero latency:
  - rd_data_x = wr_data when wr_en && wr_addr==rd_addr_x (bypass); otherwise the array entry.
  - Ports A and B are independent; both may address the same register.
- Write: on posedge, if wr_en, array[wr_addr] <= wr_data. The array updates regardless of busy state.
- busy_x = busy[rd_addr_x] && !(wr_en && wr_addr==rd_addr_x). Same-cycle writeback unblocks the read.
- iss_ack = iss_en && (!busy[iss_dst] || (wr_en && wr_addr==iss_dst)).
- Scoreboard update on posedge, per register r:
  - set = iss_ack && iss_dst==r; clr = wr_en && wr_addr==r.
  - set wins over clr: the new reservation survives its predecessor's writeback.
  - At most one outstanding reservation per register.
  - iss_en without iss_ack has no state effect; decode must hold the request and retry.
- pend_cnt next = pend_cnt + (set on a non-busy register) − (clr without set on a busy register). Must equal popcount(busy) at every cycle.
- wb_err: set on wr_en to a register whose busy bit is 0 (unreserved write). The data is still written. Cleared only by reset.
- Reset mid-operation discards all reservations; in-flight writebacks after reset release raise wb_err.

Optional Feature:
- REGFILE_ZERO_REG_EN
- Defined:
  - Register 0 always reads 0, including under bypass.
  - Writes to r0 are dropped and never raise wb_err.
  - busy[0] is constant 0; iss_dst==0 is acked whenever iss_en, with no state change.
- Undefined: r0 is an ordinary register.

Decomposition:
- regfile_pkg holds:
  - DATA_W/ADDR_W default constants.
  - typedefs reg_idx_t [ADDR_W-1:0] and reg_data_t [DATA_W-1:0].
  - NREGS localparam.
- One sub-module, regfile_scoreboard: owns the busy vector, iss_ack, pend_cnt and wb_err.
- Top level holds the data array and bypass muxes.

Test Plan:
- Reset, then read all 8 registers → rd_data 0, busy 0, pend_cnt 0. Assert rst_n low mid-run with r3=0x1234, r3 busy → r3 reads 0, pend_cnt 0 with no clock edge.
- Write r5=0xBEEF while rd_addr_a=5 same cycle → rd_data_a=0xBEEF that cycle (bypass). Next cycle without wr_en → still 0xBEEF.
- iss_en, iss_dst=2 → iss_ack=1. Next cycle: busy for r2 is 1, pend_cnt=1, and a second iss_en to r2 gets iss_ack=0 with pend_cnt still 1. Then wr_en r2=0x0042 → busy_a clears the same cycle, pend_cnt=0 after the edge.
- Same cycle: wr_en r4 (busy) and iss_en r4 → iss_ack=1, r4 stays busy, pend_cnt unchanged, data=written value.
- wr_en to r6 never issued → wb_err=1 and stays 1 for 10 cycles; r6 holds the written data.
- REGFILE_ZERO_REG_EN: write r0=0xFFFF, then read → 0. iss_en r0 → iss_ack=1, pend_cnt 0, wb_err 0.
